// File: rtl/tx_serializer.sv
// tx_serializer
// Parallel-to-serial transmitter with a one-word holding buffer. A producer
// hands over words through a valid/ready handshake. The serial line advances
// one bit for each shift_tick that arrives while tx_enable is high. A word
// waiting in the holding buffer follows the current word with no idle bit
// between them.
//
// States:
//   state | meaning
//   IDLE  | nothing shifting, tx_out at IDLE_VAL; loads as soon as a word is held and enabled
//   SHIFT | a word is on the line, bit counter tracks the bit currently driven
//
// Ports:
//   clk         in   system clock, rising edge
//   n_rst       in   asynchronous active-low reset
//   shift_tick  in   one-cycle strobe advancing the line by one bit
//   tx_enable   in   qualifies shift_tick and word start; low freezes the block
//   tx_valid    in   producer offers tx_data
//   tx_data     in   DATA_W parallel word
//   tx_ready    out  holding buffer empty
//   tx_out      out  registered serial data
//   busy        out  high while in SHIFT
//   word_done   out  one-cycle pulse when the last bit of a word is retired
module tx_serializer #(
  parameter int unsigned DATA_W    = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_VAL  = 1'b1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              shift_tick,
  input  logic              tx_enable,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              word_done
);

  localparam int unsigned       CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                hold_full_q, hold_full_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                tx_out_q, tx_out_d;
  logic                word_done_q, word_done_d;

  logic                accept;
  logic                consume;
  logic                tick;
  logic [DATA_W-1:0]   shifted;

  // Bit presented on the line for a given shifter value.
  function automatic logic out_bit(input logic [DATA_W-1:0] v);
    return MSB_FIRST ? v[DATA_W-1] : v[0];
  endfunction

  assign accept  = tx_valid && !hold_full_q;
  assign tick    = shift_tick && tx_enable;
  // Move the next bit into the output position.
  assign shifted = MSB_FIRST ? {shift_q[DATA_W-2:0], 1'b0}
                             : {1'b0, shift_q[DATA_W-1:1]};

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    tx_out_d    = tx_out_q;
    word_done_d = 1'b0;
    consume     = 1'b0;

    case (state_q)
      IDLE: begin
        if (hold_full_q && tx_enable) begin
          shift_d  = hold_q;
          cnt_d    = '0;
          consume  = 1'b1;
          state_d  = SHIFT;
          tx_out_d = out_bit(hold_q);
        end
      end
      SHIFT: begin
        if (tick) begin
          if (cnt_q != CNT_LAST) begin
            shift_d  = shifted;
            cnt_d    = cnt_q + CNT_W'(1);
            tx_out_d = out_bit(shifted);
          end else begin
            word_done_d = 1'b1;
            if (hold_full_q) begin
              // Chain the held word straight onto the line.
              shift_d  = hold_q;
              cnt_d    = '0;
              consume  = 1'b1;
              tx_out_d = out_bit(hold_q);
            end else begin
              state_d  = IDLE;
              tx_out_d = IDLE_VAL;
            end
          end
        end
      end
      default: begin
        state_d  = IDLE;
        tx_out_d = IDLE_VAL;
      end
    endcase
  end

  // Accept and consume are mutually exclusive: accept needs an empty buffer,
  // consume needs a full one.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (accept) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end else if (consume) begin
      hold_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      tx_out_q    <= IDLE_VAL;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      tx_out_q    <= tx_out_d;
      word_done_q <= word_done_d;
    end
  end

  assign tx_ready  = !hold_full_q;
  assign busy      = (state_q == SHIFT);
  assign tx_out    = tx_out_q;
  assign word_done = word_done_q;

endmodule

// File: tb/tb_tx_serializer.sv
// Testbench for tx_serializer: directed scenarios on a default instance and a
// 16-bit LSB-first instance, followed by a randomized stream checked against
// a word-queue model of the serial line.
module tb_tx_serializer;

  logic        clk;
  logic        n_rst;
  logic        shift_tick, tx_enable, tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready, tx_out, busy, word_done;

  logic        tick16, en16, valid16;
  logic [15:0] data16;
  logic        ready16, out16, busy16, done16;

  int n_pass;
  int n_total;

  tx_serializer dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .shift_tick(shift_tick),
    .tx_enable (tx_enable),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .tx_out    (tx_out),
    .busy      (busy),
    .word_done (word_done)
  );

  tx_serializer #(.DATA_W(16), .MSB_FIRST(1'b0), .IDLE_VAL(1'b0)) dut16 (
    .clk       (clk),
    .n_rst     (n_rst),
    .shift_tick(tick16),
    .tx_enable (en16),
    .tx_valid  (valid16),
    .tx_data   (data16),
    .tx_ready  (ready16),
    .tx_out    (out16),
    .busy      (busy16),
    .word_done (done16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    shift_tick = 0; tx_enable = 0; tx_valid = 0; tx_data = '0;
    tick16 = 0; en16 = 0; valid16 = 0; data16 = '0;
    step(); step();
    n_total++; if (tx_out !== 1'b1) $display("FAIL reset_tx_out got=%b exp=1", tx_out); else n_pass++;
    n_total++; if (tx_ready !== 1'b1) $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_total++; if (word_done !== 1'b0) $display("FAIL reset_word_done got=%b exp=0", word_done); else n_pass++;
    n_total++; if (out16 !== 1'b0) $display("FAIL reset_out16 got=%b exp=0", out16); else n_pass++;
    n_total++; if (ready16 !== 1'b1) $display("FAIL reset_ready16 got=%b exp=1", ready16); else n_pass++;
    n_rst = 1'b1;
    step();
  endtask

  // 0xA5 MSB first, one tick every 4 cycles.
  task automatic test_basic();
    logic [7:0] w;
    int dones;
    w = 8'hA5; dones = 0;
    tx_enable = 1;
    tx_valid = 1; tx_data = w;
    step();
    tx_valid = 0;
    n_total++; if (tx_ready !== 1'b0) $display("FAIL basic_ready_after_accept got=%b exp=0", tx_ready); else n_pass++;
    step();
    n_total++; if (busy !== 1'b1) $display("FAIL basic_busy_after_load got=%b exp=1", busy); else n_pass++;
    n_total++; if (tx_ready !== 1'b1) $display("FAIL basic_ready_after_load got=%b exp=1", tx_ready); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      repeat (3) step();
      n_total++;
      if (tx_out !== w[7-i]) $display("FAIL basic_bit%0d got=%b exp=%b", i, tx_out, w[7-i]); else n_pass++;
      shift_tick = 1; step(); shift_tick = 0;
      if (word_done) dones++;
      if (i < 7) begin
        n_total++; if (busy !== 1'b1) $display("FAIL basic_busy_mid%0d got=%b exp=1", i, busy); else n_pass++;
      end
    end
    n_total++; if (dones != 1) $display("FAIL basic_done_count got=%0d exp=1", dones); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL basic_busy_end got=%b exp=0", busy); else n_pass++;
    n_total++; if (tx_out !== 1'b1) $display("FAIL basic_idle_out got=%b exp=1", tx_out); else n_pass++;
    step();
    n_total++; if (word_done !== 1'b0) $display("FAIL basic_done_width got=%b exp=0", word_done); else n_pass++;
  endtask

  // 0x3C then 0xC3 chained with no gap.
  task automatic test_back_to_back();
    logic [15:0] s;
    int dones;
    s = 16'h3CC3; dones = 0;
    tx_enable = 1;
    tx_valid = 1; tx_data = 8'h3C;
    step();
    tx_data = 8'hC3;
    step();
    n_total++; if (busy !== 1'b1 || tx_ready !== 1'b1) $display("FAIL b2b_load busy=%b ready=%b exp=1,1", busy, tx_ready); else n_pass++;
    step();
    tx_valid = 0;
    n_total++; if (tx_ready !== 1'b0) $display("FAIL b2b_ready_second got=%b exp=0", tx_ready); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      step();
      n_total++;
      if (tx_out !== s[15-i] || busy !== 1'b1)
        $display("FAIL b2b_bit%0d got=%b busy=%b exp=%b busy=1", i, tx_out, busy, s[15-i]);
      else n_pass++;
      shift_tick = 1; step(); shift_tick = 0;
      if (word_done) dones++;
    end
    n_total++; if (dones != 2) $display("FAIL b2b_done_count got=%0d exp=2", dones); else n_pass++;
    n_total++; if (busy !== 1'b0 || tx_out !== 1'b1) $display("FAIL b2b_end busy=%b out=%b exp=0,1", busy, tx_out); else n_pass++;
  endtask

  // 16-bit LSB-first, idle low: 0x8001 -> 1, fourteen 0s, 1.
  task automatic test_wide();
    int dones;
    logic expb;
    dones = 0;
    en16 = 1;
    valid16 = 1; data16 = 16'h8001;
    step();
    valid16 = 0;
    step();
    for (int i = 0; i < 16; i++) begin
      expb = (i == 0 || i == 15) ? 1'b1 : 1'b0;
      n_total++;
      if (out16 !== expb || busy16 !== 1'b1) $display("FAIL wide_bit%0d got=%b busy=%b exp=%b", i, out16, busy16, expb); else n_pass++;
      tick16 = 1; step(); tick16 = 0;
      if (done16) dones++;
    end
    n_total++; if (dones != 1) $display("FAIL wide_done_count got=%0d exp=1", dones); else n_pass++;
    n_total++; if (out16 !== 1'b0 || busy16 !== 1'b0) $display("FAIL wide_end out=%b busy=%b exp=0,0", out16, busy16); else n_pass++;
    en16 = 0;
  endtask

  // Ticks in IDLE ignored; tx_enable low freezes mid-word.
  task automatic test_enable_freeze();
    logic [7:0] w;
    w = 8'hF0;
    tx_enable = 1;
    shift_tick = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_total++; if (tx_out !== 1'b1 || busy !== 1'b0) $display("FAIL idle_tick out=%b busy=%b exp=1,0", tx_out, busy); else n_pass++;
    end
    shift_tick = 0;
    tx_valid = 1; tx_data = w;
    step();
    tx_valid = 0;
    step();
    for (int i = 0; i < 3; i++) begin
      shift_tick = 1; step(); shift_tick = 0;
    end
    tx_enable = 0; shift_tick = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_total++;
      if (tx_out !== 1'b1 || busy !== 1'b1 || word_done !== 1'b0)
        $display("FAIL freeze_c%0d out=%b busy=%b done=%b exp=1,1,0", i, tx_out, busy, word_done);
      else n_pass++;
    end
    shift_tick = 0; tx_enable = 1;
    for (int k = 3; k < 8; k++) begin
      n_total++;
      if (tx_out !== w[7-k]) $display("FAIL resume_bit%0d got=%b exp=%b", k, tx_out, w[7-k]); else n_pass++;
      shift_tick = 1; step(); shift_tick = 0;
      n_total++;
      if (word_done !== (k == 7)) $display("FAIL resume_done%0d got=%b exp=%b", k, word_done, (k == 7)); else n_pass++;
    end
    step();
  endtask

  // Reset mid-word with a held word.
  task automatic test_reset_midword();
    logic [7:0] w;
    int dones;
    dones = 0;
    tx_enable = 1;
    tx_valid = 1; tx_data = 8'h5A;
    step();
    tx_valid = 0;
    step();
    for (int i = 0; i < 5; i++) begin
      shift_tick = 1; step(); shift_tick = 0;
    end
    tx_valid = 1; tx_data = 8'h99;
    step();
    tx_valid = 0;
    n_total++; if (tx_ready !== 1'b0) $display("FAIL rstmid_held got=%b exp=0", tx_ready); else n_pass++;
    n_rst = 1'b0;
    #1;
    n_total++;
    if (tx_out !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1 || word_done !== 1'b0)
      $display("FAIL rstmid_immediate out=%b busy=%b ready=%b done=%b exp=1,0,1,0", tx_out, busy, tx_ready, word_done);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step();
      if (word_done) dones++;
    end
    n_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (word_done) dones++;
      n_total++;
      if (busy !== 1'b0 || tx_ready !== 1'b1) $display("FAIL rstmid_discard c%0d busy=%b ready=%b exp=0,1", i, busy, tx_ready); else n_pass++;
    end
    n_total++; if (dones != 0) $display("FAIL rstmid_no_done got=%0d exp=0", dones); else n_pass++;
    w = 8'h81;
    tx_valid = 1; tx_data = w;
    step();
    tx_valid = 0;
    step();
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (tx_out !== w[7-i]) $display("FAIL rstmid_next_bit%0d got=%b exp=%b", i, tx_out, w[7-i]); else n_pass++;
      shift_tick = 1; step(); shift_tick = 0;
      if (word_done) dones++;
    end
    n_total++; if (dones != 1) $display("FAIL rstmid_next_done got=%0d exp=1", dones); else n_pass++;
  endtask

  // Data is captured only on the accepting edge.
  task automatic test_data_sampling();
    logic [7:0]  acc;
    logic [15:0] s;
    int dones;
    dones = 0;
    tx_enable = 0;
    tx_valid = 1; tx_data = 8'h12;
    step();
    for (int i = 0; i < 5; i++) begin
      tx_data = 8'($urandom);
      step();
      n_total++; if (tx_ready !== 1'b0 || busy !== 1'b0) $display("FAIL sample_wait%0d ready=%b busy=%b exp=0,0", i, tx_ready, busy); else n_pass++;
    end
    tx_enable = 1;
    tx_data = 8'($urandom);
    step();
    n_total++; if (busy !== 1'b1 || tx_ready !== 1'b1) $display("FAIL sample_load busy=%b ready=%b exp=1,1", busy, tx_ready); else n_pass++;
    acc = 8'($urandom);
    tx_data = acc;
    step();
    tx_valid = 0;
    n_total++; if (tx_ready !== 1'b0) $display("FAIL sample_accept2 got=%b exp=0", tx_ready); else n_pass++;
    s = {8'h12, acc};
    for (int i = 0; i < 16; i++) begin
      tx_data = 8'($urandom);
      step();
      n_total++;
      if (tx_out !== s[15-i]) $display("FAIL sample_bit%0d got=%b exp=%b", i, tx_out, s[15-i]); else n_pass++;
      tx_data = 8'($urandom);
      shift_tick = 1; step(); shift_tick = 0;
      if (word_done) dones++;
    end
    n_total++; if (dones != 2) $display("FAIL sample_done_count got=%0d exp=2", dones); else n_pass++;
  endtask

  // Random traffic; model = queue of bits of every accepted word in order.
  task automatic test_random();
    logic exp_bits[$];
    int words, dones, guard;
    logic drained;
    words = 0; dones = 0; drained = 1'b0;
    for (int c = 0; c < 1100; c++) begin
      if (c < 800) begin
        tx_valid   = ($urandom_range(0, 1) == 1);
        tx_data    = 8'($urandom);
        shift_tick = ($urandom_range(0, 2) == 0);
        tx_enable  = ($urandom_range(0, 4) != 0);
      end else begin
        tx_valid   = 0;
        tx_data    = 8'($urandom);
        shift_tick = 1;
        tx_enable  = 1;
        if (!busy && tx_ready) begin
          drained = 1'b1;
          break;
        end
      end
      if (tx_valid && tx_ready) begin
        for (int b = 7; b >= 0; b--) exp_bits.push_back(tx_data[b]);
        words++;
      end
      if (shift_tick && tx_enable && busy) begin
        n_total++;
        if (exp_bits.size() == 0) $display("FAIL rand_extra_bit cycle=%0d got=%b exp=none", c, tx_out);
        else begin
          logic e;
          e = exp_bits.pop_front();
          if (tx_out !== e) $display("FAIL rand_bit cycle=%0d got=%b exp=%b", c, tx_out, e); else n_pass++;
        end
      end
      step();
      if (word_done) dones++;
      if (!busy) begin
        n_total++;
        if (tx_out !== 1'b1) $display("FAIL rand_idle_out cycle=%0d got=%b exp=1", c, tx_out); else n_pass++;
      end
    end
    guard = 0;
    n_total++; if (!drained) $display("FAIL rand_drain_timeout busy=%b ready=%b exp=0,1", busy, tx_ready); else n_pass++;
    n_total++; if (exp_bits.size() != guard) $display("FAIL rand_leftover_bits got=%0d exp=0", exp_bits.size()); else n_pass++;
    n_total++; if (dones != words) $display("FAIL rand_done_count got=%0d exp=%0d", dones, words); else n_pass++;
    n_total++; if (words < 10) $display("FAIL rand_words_accepted got=%0d exp>=10", words); else n_pass++;
    shift_tick = 0;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_wide();
    test_enable_freeze();
    test_reset_midword();
    test_data_sampling();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tx_serializer.md
TX_SERIALIZER -- requirements
Module: tx_serializer

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, serial word width in bits; legal range 2..32.
REQ-002 SHALL provide parameter MSB_FIRST, default 1; 1 = transmit bit DATA_W-1 first, 0 = bit 0 first.
REQ-003 SHALL provide parameter IDLE_VAL, default 1, level driven on tx_out when no word is shifting.
REQ-004 SHALL provide port clk  input  1  system clock; all state updates on its rising edge.
REQ-005 SHALL provide port n_rst  input  1  reset; asynchronous, active-low.
REQ-006 SHALL provide port shift_tick  input  1  single-cycle strobe advancing the serial line one bit, e.g. an SCK falling-edge detect.
REQ-007 SHALL provide port tx_enable  input  1  qualifies shift_tick and word start; low freezes the block.
REQ-008 SHALL provide port tx_valid  input  1  producer offers tx_data this cycle.
REQ-009 SHALL provide port tx_data  input  DATA_W  parallel word to transmit.
REQ-010 SHALL provide port tx_ready  output  1  holding buffer empty; word accepted when tx_valid && tx_ready.
REQ-011 SHALL provide port tx_out  output  1  registered serial data.
REQ-012 SHALL provide port busy  output  1  high while in SHIFT.
REQ-013 SHALL provide port word_done  output  1  one-cycle pulse when the last bit of a word is retired.

Function
REQ-014 SHALL contain a DATA_W holding register with flag hold_full, a DATA_W shift register, and a bit counter of width $clog2(DATA_W).
REQ-015 SHALL drive tx_ready = !hold_full combinationally; accepting a word sets hold_full on the next edge.
REQ-016 SHALL implement two states: IDLE and SHIFT; busy = (state == SHIFT).
REQ-017 IDLE: when hold_full && tx_enable, SHALL load the shifter from the holding register, clear hold_full, set bit counter to 0, enter SHIFT; first bit appears on tx_out the cycle after the load edge.
REQ-018 SHIFT: shift_tick && tx_enable with counter < DATA_W-1 SHALL shift one position toward the output end and increment the counter.
REQ-019 SHIFT: shift_tick && tx_enable with counter == DATA_W-1 SHALL pulse word_done for exactly that next cycle.
REQ-020 At that last-bit tick, if hold_full SHALL reload from the holding register, clear hold_full, reset counter to 0, stay in SHIFT, with no idle bit between words.
REQ-021 At that last-bit tick, if !hold_full SHALL enter IDLE and drive tx_out = IDLE_VAL.
REQ-022 tx_out SHALL equal shifter bit DATA_W-1 when MSB_FIRST=1, bit 0 when MSB_FIRST=0, while in SHIFT.
REQ-023 shift_tick with tx_enable low, or in IDLE, SHALL be ignored; all state, counter, and tx_out hold.
REQ-024 Acceptance SHALL be independent of tx_enable and state; a word offered while SHIFT with empty hold is buffered.
REQ-025 Acceptance and hold consumption SHALL never coincide, since tx_ready is low whenever hold is full.
REQ-026 tx_data SHALL be sampled only on the accepting edge; later changes have no effect.

Reset
REQ-027 n_rst low SHALL immediately force: state IDLE, hold_full 0, shifter 0, counter 0, tx_out IDLE_VAL, tx_ready 1, busy 0, word_done 0.
REQ-028 Reset mid-word SHALL discard both the shifting word and any held word without emitting word_done.
REQ-029 Release of n_rst SHALL require no further initialisation; the first accepted word starts per REQ-017.

Verification
REQ-030 Defaults, accept 0xA5, ticks every 4 cycles -> tx_out 1,0,1,0,0,1,0,1; one word_done on 8th tick; then tx_out=1, busy=0.
REQ-031 Accept 0x3C, then 0xC3 during shifting -> tx_ready low after second accept; 16 consecutive bits 00111100 11000011, no idle gap; two word_done pulses.
REQ-032 DATA_W=16, MSB_FIRST=0, IDLE_VAL=0, send 0x8001 -> tx_out 1, fourteen 0s, 1; then 0.
REQ-033 tx_enable low for 10 cycles after 3rd bit of 0xF0, ticks continuing -> tx_out frozen at 1, counter stays 3; resumes with 4th bit.
REQ-034 Assert n_rst low after 5th bit with a word held -> outputs immediately at reset values; no word_done; next word transmits from its first bit.
REQ-035 tx_valid held high with changing tx_data while tx_ready low -> only the value present on the accepting edge is transmitted.
